screen_writer: RTL and testbench
================================

# screen_writer

Write-side controller for the text screen memory. Accepts a stream of 7-bit character codes through a valid/ready handshake, keeps a cursor, and issues one-word writes (address, data, enable) into the COLS×ROWS character RAM that the display path reads. It interprets a small set of control codes, blanks new rows as the cursor reaches them, and blanks the whole screen after reset.

## Interface
- DATA_WIDTH, 7, character code width.
- ADDR_WIDTH, 11, screen memory address width.
- COLS, 80, characters per row.
- ROWS, 25, rows per screen. COLS*ROWS ≤ 2**ADDR_WIDTH is required.
- clock  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- char_valid  in  1  char_data holds a code to consume.
- char_data  in  DATA_WIDTH  character code.
- char_ready  out  1  block can accept a code this cycle.
- wr_en  out  1  memory write strobe, one word per cycle.
- wr_addr  out  ADDR_WIDTH  write address, equal to row*COLS+col.
- wr_data  out  DATA_WIDTH  write data.
- cursor_addr  out  ADDR_WIDTH  current cursor address, for the display blink.
- busy  out  1  a row or screen clear is in progress.

## Operation
- States: CLEAR_ALL, IDLE, CLEAR_ROW.
- Transfer occurs on a rising edge with char_valid=1 and char_ready=1. char_ready equals (state==IDLE). A code offered while char_ready=0 is held and not consumed.
- Cursor: col in 0..COLS-1, row in 0..ROWS-1, row_base = row*COLS. row_base is updated by adding COLS, or resetting to 0 on wrap; no multiplier.
- Printable code (0x20–0x7E) writes the code at the cursor, then col+1.
  - If col was COLS-1: col=0, row advances, and the state enters CLEAR_ROW.
- 0x0A (LF): no write. col=0, row advances, enter CLEAR_ROW.
- 0x0D (CR): no write. col=0.
- 0x08 (BS): if col>0, col-1 and write 0x20 at the new position. At col=0 it is a no-op.
- 0x0C (FF): col=row=0, enter CLEAR_ALL.
- Any other code (0x00–0x1F not listed, 0x7F) is consumed and ignored.
- Row advance: row ROWS-1 wraps to 0 (no scrolling).
- CLEAR_ROW writes 0x20 to row_base+0 … row_base+COLS-1 of the new row, one per cycle, then returns to IDLE.
- CLEAR_ALL writes 0x20 to addresses 0 … COLS*ROWS-1, one per cycle, then returns to IDLE with the cursor at 0.
- busy = (state != IDLE).

## Timing
- Reset values:
  - state=CLEAR_ALL, char_ready=0, busy=1.
  - wr_en=0, wr_addr=0, wr_data=0.
  - cursor_addr=0, col=row=row_base=0, clear counter=0.
- All outputs are registered.
  - A write caused by a transfer at edge N is presented with wr_en=1 in the cycle after edge N.
  - cursor_addr reflects the new position in that same cycle.
- Throughput is one printable code per cycle while no row boundary is crossed; char_ready stays high.
- Row clear:
  - The first clear write is in the cycle after the transfer edge.
  - There are exactly COLS clear write cycles.
  - char_ready rises in the cycle after the last clear write.
  - The char written at col COLS-1 precedes the row clear, so total wr_en cycles = 1+COLS.
- Screen clear: exactly COLS*ROWS write cycles with consecutive addresses. After reset the first write is in the first cycle after reset_n deasserts.
- wr_en=0 in every IDLE cycle with no accepted write-producing code.
- reset_n asserted mid-clear or mid-write aborts immediately: wr_en=0 asynchronously, and the clear restarts from address 0.

## Test plan
- Reset release:
  - 2000 consecutive wr_en cycles, addresses 0…1999, data 0x20.
  - Then char_ready=1, cursor_addr=0, wr_en=0.
- Send 'H','i' (0x48,0x69) back-to-back:
  - Writes (0,0x48) then (1,0x69) on consecutive cycles.
  - char_ready stays 1; cursor_addr=2.
- From col 78, row 0, send 0x41,0x42:
  - Writes (78,0x41) and (79,0x42).
  - Then 80 writes of 0x20 at addresses 80…159, with char_ready=0 and busy=1.
  - Ends with cursor_addr=80.
- From row 24, col 5, send 0x0A:
  - No character write.
  - Clear of addresses 0…79; cursor_addr=0.
- From col 3, send 0x08: write (2,0x20), cursor_addr=2. From col 0, send 0x08: no write, cursor unchanged.
- Send 0x0C mid-screen:
  - 2000-cycle clear with a code held on char_valid; the held code is not consumed until char_ready=1.
  - reset_n pulsed at clear address 500: wr_en drops and the clear restarts at address 0.

Source files
------------

// File: rtl/screen_writer.sv
// screen_writer
// Write-side controller for the text screen memory. Character codes arrive
// through a valid/ready handshake; printable codes are written at the cursor,
// a few control codes move the cursor, and rows / the whole screen are blanked
// with spaces as the cursor reaches them or after reset / form feed.
//
// Ports
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   char_valid   char_data holds a code to consume
//   char_data    character code
//   char_ready   a code can be accepted this cycle (state is IDLE)
//   wr_en        one-word write strobe into the character RAM
//   wr_addr      write address (row*COLS + col)
//   wr_data      write data
//   cursor_addr  current cursor address
//   busy         a row or screen clear is in progress
module screen_writer #(
  parameter int DATA_WIDTH = 7,
  parameter int ADDR_WIDTH = 11,
  parameter int COLS       = 80,
  parameter int ROWS       = 25
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  char_valid,
  input  logic [DATA_WIDTH-1:0] char_data,
  output logic                  char_ready,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [ADDR_WIDTH-1:0] cursor_addr,
  output logic                  busy
);

  // One extra bit so the counter can hold COLS*ROWS itself as the "done" mark.
  localparam int CW = ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] COLS_A     = ADDR_WIDTH'(COLS);
  localparam logic [ADDR_WIDTH-1:0] LAST_COL   = ADDR_WIDTH'(COLS - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ROW   = ADDR_WIDTH'(ROWS - 1);
  localparam logic [CW-1:0]         ROW_END    = CW'(COLS);
  localparam logic [CW-1:0]         SCREEN_END = CW'(COLS * ROWS);

  localparam logic [DATA_WIDTH-1:0] SPACE   = DATA_WIDTH'(7'h20);
  localparam logic [DATA_WIDTH-1:0] TILDE   = DATA_WIDTH'(7'h7E);
  localparam logic [DATA_WIDTH-1:0] CODE_BS = DATA_WIDTH'(7'h08);
  localparam logic [DATA_WIDTH-1:0] CODE_LF = DATA_WIDTH'(7'h0A);
  localparam logic [DATA_WIDTH-1:0] CODE_FF = DATA_WIDTH'(7'h0C);
  localparam logic [DATA_WIDTH-1:0] CODE_CR = DATA_WIDTH'(7'h0D);

  typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] col_q, col_d;
  logic [ADDR_WIDTH-1:0] row_q, row_d;
  logic [ADDR_WIDTH-1:0] row_base_q, row_base_d;
  logic [CW-1:0]         clr_cnt_q, clr_cnt_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [ADDR_WIDTH-1:0] cursor_addr_q, cursor_addr_d;
  logic                  char_ready_q, char_ready_d;
  logic                  busy_q, busy_d;

  logic                  transfer;
  logic                  printable;
  logic [ADDR_WIDTH-1:0] adv_row;
  logic [ADDR_WIDTH-1:0] adv_base;

  // The clear counter always names the next address to blank; a clear-starting
  // code issues address 0 of the clear itself, so the first blanking write lands
  // in the cycle right after the transfer. Every output is computed from the
  // next state so it is registered yet aligned with state: char_ready stays low
  // through the last clear write and rises one cycle later.
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    clr_cnt_d  = clr_cnt_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    transfer  = char_valid && char_ready_q;
    printable = (char_data >= SPACE) && (char_data <= TILDE);
    adv_row   = (row_q == LAST_ROW) ? '0 : row_q + ADDR_WIDTH'(1);
    adv_base  = (row_q == LAST_ROW) ? '0 : row_base_q + COLS_A;

    case (state_q)
      CLEAR_ALL: begin
        if (clr_cnt_q == SCREEN_END) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = clr_cnt_q[ADDR_WIDTH-1:0];
          wr_data_d = SPACE;
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end

      CLEAR_ROW: begin
        if (clr_cnt_q == ROW_END) begin
          state_d   = IDLE;
          clr_cnt_d = '0;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = row_base_q + clr_cnt_q[ADDR_WIDTH-1:0];
          wr_data_d = SPACE;
          clr_cnt_d = clr_cnt_q + CW'(1);
        end
      end

      default: begin
        if (transfer) begin
          if (printable) begin
            wr_en_d   = 1'b1;
            wr_addr_d = row_base_q + col_q;
            wr_data_d = char_data;
            if (col_q == LAST_COL) begin
              // The character goes out first; the new row is blanked after it.
              col_d      = '0;
              row_d      = adv_row;
              row_base_d = adv_base;
              clr_cnt_d  = '0;
              state_d    = CLEAR_ROW;
            end else begin
              col_d = col_q + ADDR_WIDTH'(1);
            end
          end else begin
            case (char_data)
              CODE_LF: begin
                col_d      = '0;
                row_d      = adv_row;
                row_base_d = adv_base;
                wr_en_d    = 1'b1;
                wr_addr_d  = adv_base;
                wr_data_d  = SPACE;
                clr_cnt_d  = CW'(1);
                state_d    = CLEAR_ROW;
              end
              CODE_CR: begin
                col_d = '0;
              end
              CODE_BS: begin
                if (col_q != '0) begin
                  col_d     = col_q - ADDR_WIDTH'(1);
                  wr_en_d   = 1'b1;
                  wr_addr_d = row_base_q + col_q - ADDR_WIDTH'(1);
                  wr_data_d = SPACE;
                end
              end
              CODE_FF: begin
                col_d      = '0;
                row_d      = '0;
                row_base_d = '0;
                wr_en_d    = 1'b1;
                wr_addr_d  = '0;
                wr_data_d  = SPACE;
                clr_cnt_d  = CW'(1);
                state_d    = CLEAR_ALL;
              end
              default: begin
              end
            endcase
          end
        end
      end
    endcase

    char_ready_d  = (state_d == IDLE);
    busy_d        = (state_d != IDLE);
    cursor_addr_d = row_base_d + col_d;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= CLEAR_ALL;
      col_q         <= '0;
      row_q         <= '0;
      row_base_q    <= '0;
      clr_cnt_q     <= '0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      cursor_addr_q <= '0;
      char_ready_q  <= 1'b0;
      busy_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      col_q         <= col_d;
      row_q         <= row_d;
      row_base_q    <= row_base_d;
      clr_cnt_q     <= clr_cnt_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      cursor_addr_q <= cursor_addr_d;
      char_ready_q  <= char_ready_d;
      busy_q        <= busy_d;
    end
  end

  assign char_ready  = char_ready_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cursor_addr = cursor_addr_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_screen_writer.sv
// tb_screen_writer
// Directed testbench for screen_writer (80x25 screen, 7-bit codes).
// Outputs are sampled 1 time unit after each rising clock edge; inputs are
// changed at the same point so they are stable for the next edge.
module tb_screen_writer;

  logic        clock;
  logic        reset_n;
  logic        char_valid;
  logic [6:0]  char_data;
  logic        char_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [6:0]  wr_data;
  logic [10:0] cursor_addr;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  screen_writer #(
    .DATA_WIDTH(7),
    .ADDR_WIDTH(11),
    .COLS(80),
    .ROWS(25)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .char_valid(char_valid),
    .char_data(char_data),
    .char_ready(char_ready),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .cursor_addr(cursor_addr),
    .busy(busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net so the run always ends even if the sequence stalls.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance to the sampling point of the next cycle.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Drive the handshake inputs.
  task automatic applyStimulus(input logic valid, input logic [6:0] code);
    char_valid = valid;
    char_data  = code;
  endtask

  // Single compare point; every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expects n consecutive space writes starting at start_addr, with the cursor
  // parked at exp_cursor and the block busy; leaves the bench at the cycle
  // after the last expected write.
  task automatic clearRun(input string tag, input int start_addr, input int n, input int exp_cursor);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      if (!(wr_en === 1'b1 && wr_addr === 11'(start_addr + i) && wr_data === 7'h20 &&
            char_ready === 1'b0 && busy === 1'b1 && cursor_addr === 11'(exp_cursor)))
        errs++;
      step();
    end
    checkOutput(tag, 32'(errs), 32'd0);
  endtask

  // Sends n back-to-back printable codes from the current cursor.
  task automatic printRun(input string tag, input int start_addr, input int n, input logic [6:0] code);
    int errs;
    errs = 0;
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, code);
      step();
      if (!(wr_en === 1'b1 && wr_addr === 11'(start_addr + i) && wr_data === code &&
            char_ready === 1'b1 && cursor_addr === 11'(start_addr + i + 1)))
        errs++;
    end
    applyStimulus(1'b0, 7'h00);
    checkOutput(tag, 32'(errs), 32'd0);
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 7'h00);
    repeat (3) step();

    // Reset state.
    checkOutput("rst_wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst_wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("rst_wr_data", 32'(wr_data), 32'd0);
    checkOutput("rst_ready", 32'(char_ready), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd1);
    checkOutput("rst_cursor", 32'(cursor_addr), 32'd0);

    // Power-up screen clear: 2000 writes, then idle at the home position.
    reset_n = 1'b1;
    step();
    clearRun("reset_clear", 0, 2000, 0);
    checkOutput("post_clear_ready", 32'(char_ready), 32'd1);
    checkOutput("post_clear_busy", 32'(busy), 32'd0);
    checkOutput("post_clear_wr_en", 32'(wr_en), 32'd0);
    checkOutput("post_clear_cursor", 32'(cursor_addr), 32'd0);

    // "Hi" back-to-back.
    applyStimulus(1'b1, 7'h48);
    step();
    checkOutput("H_wr_en", 32'(wr_en), 32'd1);
    checkOutput("H_addr", 32'(wr_addr), 32'd0);
    checkOutput("H_data", 32'(wr_data), 32'h48);
    checkOutput("H_ready", 32'(char_ready), 32'd1);
    applyStimulus(1'b1, 7'h69);
    step();
    checkOutput("i_wr_en", 32'(wr_en), 32'd1);
    checkOutput("i_addr", 32'(wr_addr), 32'd1);
    checkOutput("i_data", 32'(wr_data), 32'h69);
    checkOutput("i_ready", 32'(char_ready), 32'd1);
    checkOutput("i_cursor", 32'(cursor_addr), 32'd2);
    applyStimulus(1'b0, 7'h00);
    step();
    checkOutput("idle_wr_en", 32'(wr_en), 32'd0);
    checkOutput("idle_cursor", 32'(cursor_addr), 32'd2);

    // Fill up to col 78, then wrap at the end of row 0.
    printRun("fill_row0", 2, 76, 7'h2E);
    applyStimulus(1'b1, 7'h41);
    step();
    checkOutput("A78_addr", 32'(wr_addr), 32'd78);
    checkOutput("A78_data", 32'(wr_data), 32'h41);
    checkOutput("A78_ready", 32'(char_ready), 32'd1);
    applyStimulus(1'b1, 7'h42);
    step();
    checkOutput("B79_wr_en", 32'(wr_en), 32'd1);
    checkOutput("B79_addr", 32'(wr_addr), 32'd79);
    checkOutput("B79_data", 32'(wr_data), 32'h42);
    checkOutput("B79_ready", 32'(char_ready), 32'd0);
    checkOutput("B79_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 7'h00);
    step();
    clearRun("wrap_row_clear", 80, 80, 80);
    checkOutput("wrap_ready", 32'(char_ready), 32'd1);
    checkOutput("wrap_wr_en", 32'(wr_en), 32'd0);
    checkOutput("wrap_cursor", 32'(cursor_addr), 32'd80);

    // Line feeds down to row 24; each one blanks the row it enters.
    for (int r = 1; r < 24; r++) begin
      applyStimulus(1'b1, 7'h0A);
      step();
      applyStimulus(1'b0, 7'h00);
      clearRun("lf_row_clear", (r + 1) * 80, 80, (r + 1) * 80);
    end
    checkOutput("row24_cursor", 32'(cursor_addr), 32'd1920);
    printRun("fill_row24", 1920, 5, 7'h61);

    // LF on the last row wraps to row 0 with no character write.
    applyStimulus(1'b1, 7'h0A);
    step();
    applyStimulus(1'b0, 7'h00);
    clearRun("lf_wrap_clear", 0, 80, 0);
    checkOutput("lf_wrap_ready", 32'(char_ready), 32'd1);
    checkOutput("lf_wrap_cursor", 32'(cursor_addr), 32'd0);

    // Backspace at col 0 is a no-op.
    applyStimulus(1'b1, 7'h08);
    step();
    applyStimulus(1'b0, 7'h00);
    checkOutput("bs0_wr_en", 32'(wr_en), 32'd0);
    checkOutput("bs0_cursor", 32'(cursor_addr), 32'd0);

    // Backspace at col 3 blanks col 2.
    printRun("fill_bs", 0, 3, 7'h78);
    applyStimulus(1'b1, 7'h08);
    step();
    applyStimulus(1'b0, 7'h00);
    checkOutput("bs3_wr_en", 32'(wr_en), 32'd1);
    checkOutput("bs3_addr", 32'(wr_addr), 32'd2);
    checkOutput("bs3_data", 32'(wr_data), 32'h20);
    checkOutput("bs3_cursor", 32'(cursor_addr), 32'd2);

    // CR returns to col 0 without writing; unknown codes are ignored.
    applyStimulus(1'b1, 7'h0D);
    step();
    checkOutput("cr_wr_en", 32'(wr_en), 32'd0);
    checkOutput("cr_cursor", 32'(cursor_addr), 32'd0);
    printRun("fill_ign", 0, 4, 7'h79);
    applyStimulus(1'b1, 7'h01);
    step();
    checkOutput("ign01_wr_en", 32'(wr_en), 32'd0);
    checkOutput("ign01_cursor", 32'(cursor_addr), 32'd4);
    applyStimulus(1'b1, 7'h7F);
    step();
    applyStimulus(1'b0, 7'h00);
    checkOutput("ign7f_wr_en", 32'(wr_en), 32'd0);
    checkOutput("ign7f_cursor", 32'(cursor_addr), 32'd4);
    checkOutput("ign7f_ready", 32'(char_ready), 32'd1);

    // Form feed: screen clear with a code held on the input, reset at 500.
    applyStimulus(1'b1, 7'h0C);
    step();
    applyStimulus(1'b1, 7'h5A);
    checkOutput("ff_cursor", 32'(cursor_addr), 32'd0);
    clearRun("ff_clear_head", 0, 500, 0);
    checkOutput("ff_at500_wr_en", 32'(wr_en), 32'd1);
    checkOutput("ff_at500_addr", 32'(wr_addr), 32'd500);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_wr_en", 32'(wr_en), 32'd0);
    checkOutput("abort_addr", 32'(wr_addr), 32'd0);
    checkOutput("abort_ready", 32'(char_ready), 32'd0);
    #1;
    reset_n = 1'b1;
    step();
    clearRun("restart_clear", 0, 2000, 0);
    checkOutput("restart_ready", 32'(char_ready), 32'd1);
    checkOutput("restart_wr_en", 32'(wr_en), 32'd0);
    step();
    applyStimulus(1'b0, 7'h00);
    checkOutput("held_wr_en", 32'(wr_en), 32'd1);
    checkOutput("held_addr", 32'(wr_addr), 32'd0);
    checkOutput("held_data", 32'(wr_data), 32'h5A);
    checkOutput("held_cursor", 32'(cursor_addr), 32'd1);
    step();
    checkOutput("held_once_wr_en", 32'(wr_en), 32'd0);
    checkOutput("held_once_cursor", 32'(cursor_addr), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
